// File: rtl/fb_out_scheduler.sv
// fb_out_scheduler: captures decimated filter-bank band samples into per-band
// holding registers and serialises them onto a single valid/ready stream,
// granting pending bands in round-robin order.
// Optional feature: define FB_SCHED_OVERRUN_EN to build the sticky overrun
// flag; without it overrun is tied low and overrun_clr is ignored.
module fb_out_scheduler #(
    parameter int NCH  = 16,
    parameter int DW   = 37,
    parameter int DECW = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clk_enable,
    input  logic [NCH*DW-1:0]      band_data,
    input  logic [NCH*DECW-1:0]    dec_cfg,
    input  logic                   cfg_load,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(NCH)-1:0] out_chan,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int CW = $clog2(NCH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [DECW-1:0] dec_q     [NCH];
    logic [DECW-1:0] phase_q   [NCH];
    logic [DW-1:0]   holding_q [NCH];

    logic [NCH-1:0]  pending_q;
    logic [NCH-1:0]  pending_d;
    logic [NCH-1:0]  due;

    logic [CW-1:0]   grant_q;
    logic [CW-1:0]   grant_d;
    logic [CW-1:0]   last_q;
    logic [CW-1:0]   pick;
    logic [CW:0]     idx;

    logic            any_pending;
    logic            xfer;

    assign any_pending = |pending_q;
    assign xfer        = (state_q == PRESENT) && out_ready;
    assign out_chan    = grant_q;
    assign out_data    = holding_q[grant_q];

    // Decide which bands capture on this strobe and how the pending set evolves
    always_comb begin
        due       = '0;
        pending_d = pending_q;
        for (int k = 0; k < NCH; k++) begin
            due[k] = clk_enable && !cfg_load && (phase_q[k] == '0);
            if (due[k]) begin
                pending_d[k] = 1'b1;
            end else if (xfer && (grant_q == CW'(k))) begin
                pending_d[k] = 1'b0;
            end
        end
    end

    // Round-robin search upward from the band after the last grant; scanning
    // from the far end lets the nearest pending band win without a found flag
    always_comb begin
        pick = last_q;
        idx  = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = {1'b0, last_q} + (CW+1)'(i);
            if (idx >= (CW+1)'(NCH)) begin
                idx = idx - (CW+1)'(NCH);
            end
            if (pending_q[idx[CW-1:0]]) begin
                pick = idx[CW-1:0];
            end
        end
    end

    // Per-band decimation registers, phase counters, holding registers and pending bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                dec_q[k]     <= '0;
                phase_q[k]   <= '0;
                holding_q[k] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (cfg_load) begin
                    dec_q[k]   <= dec_cfg[k*DECW +: DECW];
                    phase_q[k] <= '0;
                end else if (clk_enable) begin
                    if (due[k]) begin
                        phase_q[k]   <= dec_q[k];
                        holding_q[k] <= band_data[k*DW +: DW];
                    end else begin
                        phase_q[k] <= phase_q[k] - DECW'(1);
                    end
                end
            end
            pending_q <= pending_d;
        end
    end

    // Output FSM state, current grant and round-robin pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CW'(NCH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if ((state_q == IDLE) && any_pending) begin
                last_q <= pick;
            end
        end
    end

    // Next-state and output decode: grant is chosen on the IDLE->PRESENT step
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = PRESENT;
                    grant_d = pick;
                end
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FB_SCHED_OVERRUN_EN
    logic [NCH-1:0] ovr_evt;

    // A due band overwriting a pending sample that is not leaving this cycle
    always_comb begin
        ovr_evt = '0;
        for (int k = 0; k < NCH; k++) begin
            ovr_evt[k] = due[k] && pending_q[k] && !(xfer && (grant_q == CW'(k)));
        end
    end

    // Sticky overrun flag; a new event beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (|ovr_evt) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = overrun_clr;
    assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_fb_out_scheduler.sv
// Testbench for fb_out_scheduler: directed vectors for the documented corner
// cases followed by a randomized run against a behavioural reference model.
module tb_fb_out_scheduler;

    localparam int NCH  = 16;
    localparam int DW   = 37;
    localparam int DECW = 4;
    localparam int CW   = $clog2(NCH);

`ifdef FB_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                clk_enable = 1'b0;
    logic [NCH*DW-1:0]   band_data = '0;
    logic [NCH*DECW-1:0] dec_cfg = '0;
    logic                cfg_load = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DW-1:0]       out_data;
    logic [CW-1:0]       out_chan;
    logic                overrun;
    logic                overrun_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] band_in;
        int            exp_chan;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [NCH];

    // Reference model state: strobe counts since the last configuration load
    int            m_dec  [NCH];
    int            m_cnt  [NCH];
    logic [DW-1:0] m_hold [NCH];
    bit            m_pend [NCH];
    bit            m_present;
    int            m_chan;
    int            m_last;
    bit            m_ovr;

    int            emit_cnt [NCH];
    logic [DW-1:0] band3_last;
    logic [DW-1:0] rec_data;
    logic [CW-1:0] rec_chan;

    fb_out_scheduler #(
        .NCH  (NCH),
        .DW   (DW),
        .DECW (DECW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clk_enable  (clk_enable),
        .band_data   (band_data),
        .dec_cfg     (dec_cfg),
        .cfg_load    (cfg_load),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit ce, input bit cl, input bit rdy, input bit clr);
        clk_enable  = ce;
        cfg_load    = cl;
        out_ready   = rdy;
        overrun_clr = clr;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < NCH; k++) begin
            m_dec[k]  = 0;
            m_cnt[k]  = 0;
            m_hold[k] = '0;
            m_pend[k] = 1'b0;
        end
        m_present = 1'b0;
        m_chan    = 0;
        m_last    = NCH - 1;
        m_ovr     = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        band_data = '0;
        dec_cfg   = '0;
        repeat (2) cycle();
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic waitValid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            cycle();
            n++;
        end
        checkOutput(name, 64'(out_valid), 64'd1);
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic modelStep();
        bit old_pend [NCH];
        bit xfer;
        bit strobe;
        bit due;
        bit evt;
        old_pend = m_pend;
        xfer     = m_present && out_ready;
        strobe   = clk_enable && !cfg_load;
        evt      = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            due = strobe && ((m_cnt[k] % (m_dec[k] + 1)) == 0);
            if (due) begin
                if (m_pend[k] && !(xfer && m_chan == k)) evt = 1'b1;
                m_hold[k] = band_data[k*DW +: DW];
                m_pend[k] = 1'b1;
            end else if (xfer && m_chan == k) begin
                m_pend[k] = 1'b0;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (cfg_load) begin
                m_dec[k] = int'(dec_cfg[k*DECW +: DECW]);
                m_cnt[k] = 0;
            end else if (strobe) begin
                m_cnt[k]++;
            end
        end
        if (OVR_EN) begin
            if (evt) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
        if (m_present) begin
            if (out_ready) m_present = 1'b0;
        end else begin
            for (int i = NCH; i >= 1; i--) begin
                if (old_pend[(m_last + i) % NCH]) begin
                    m_chan    = (m_last + i) % NCH;
                    m_present = 1'b1;
                end
            end
            if (m_present) m_last = m_chan;
        end
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) begin
            vecs[k].band_in  = DW'(k + 1);
            vecs[k].exp_chan = k;
            vecs[k].exp_data = DW'(k + 1);
        end

        // Reset values
        doReset();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_chan", 64'(out_chan), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);

        // One strobe with every band due, drained in ascending order
        for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = vecs[k].band_in;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NCH; i++) begin
            waitValid("t032_valid", 8);
            checkOutput("t032_chan", 64'(out_chan), 64'(vecs[i].exp_chan));
            checkOutput("t032_data", 64'(out_data), 64'(vecs[i].exp_data));
            cycle();
        end
        repeat (3) cycle();
        checkOutput("t032_drained", 64'(out_valid), 64'd0);

        // Band 3 decimates by 4, the rest by 16
        doReset();
        for (int k = 0; k < NCH; k++) begin
            dec_cfg[k*DECW +: DECW] = (k == 3) ? DECW'(3) : DECW'(15);
            emit_cnt[k] = 0;
        end
        band3_last = '0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        for (int s = 1; s <= 8; s++) begin
            for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = DW'(s);
            for (int c = 0; c < 40; c++) begin
                applyStimulus(c == 0, 1'b0, 1'b1, 1'b0);
                if (out_valid) begin
                    emit_cnt[out_chan]++;
                    if (out_chan == CW'(3)) band3_last = out_data;
                end
                cycle();
            end
        end
        for (int k = 0; k < NCH; k++) begin
            checkOutput($sformatf("t033_count_band%0d", k), 64'(emit_cnt[k]), (k == 3) ? 64'd2 : 64'd1);
        end
        checkOutput("t033_band3_data", 64'(band3_last), 64'd5);

        // Backpressure holds the presented sample stable
        doReset();
        for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = DW'({$urandom(), $urandom()});
        rec_data = band_data[0 +: DW];
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("t034_valid", 4);
        checkOutput("t034_first_chan", 64'(out_chan), 64'd0);
        checkOutput("t034_first_data", 64'(out_data), 64'(rec_data));
        rec_chan = CW'(0);
        for (int c = 0; c < 10; c++) begin
            cycle();
            checkOutput("t034_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("t034_hold_chan", 64'(out_chan), 64'(rec_chan));
            checkOutput("t034_hold_data", 64'(out_data), 64'(rec_data));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        checkOutput("t034_transfer", 64'(out_valid), 64'd0);

        // Two strobes without draining: overwrite and overrun
        doReset();
        for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = DW'(32'h100 + k);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        checkOutput("t035_no_overrun_yet", 64'(overrun), 64'd0);
        for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = DW'(32'h200 + k);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t035_overrun", 64'(overrun), 64'(OVR_EN));
        checkOutput("t035_overwrite_chan", 64'(out_chan), 64'd0);
        checkOutput("t035_overwrite_data", 64'(out_data), 64'h200);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NCH; i++) begin
            waitValid("t035_valid", 8);
            checkOutput("t035_chan", 64'(out_chan), 64'(i));
            checkOutput("t035_data", 64'(out_data), 64'(32'h200 + i));
            cycle();
        end
        checkOutput("t035_overrun_sticky", 64'(overrun), 64'(OVR_EN));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t035_overrun_cleared", 64'(overrun), 64'd0);

        // Asynchronous reset while presenting
        doReset();
        for (int k = 0; k < NCH; k++) band_data[k*DW +: DW] = DW'(32'h300 + k);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("t036_valid", 4);
        reset_n = 1'b0;
        #1;
        checkOutput("t036_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("t036_chan_zero", 64'(out_chan), 64'd0);
        checkOutput("t036_data_zero", 64'(out_data), 64'd0);
        cycle();
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle();
            checkOutput("t036_no_pending", 64'(out_valid), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitValid("t036_regrant_valid", 4);
        checkOutput("t036_first_grant", 64'(out_chan), 64'd0);

        // Randomized run against the reference model
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NCH; k++) begin
                band_data[k*DW +: DW] = DW'({$urandom(), $urandom()});
                dec_cfg[k*DECW +: DECW] = DECW'($urandom_range(0, 3));
            end
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 20) == 0);
            modelStep();
            cycle();
            checkOutput("rnd_valid", 64'(out_valid), 64'(m_present));
            if (m_present) begin
                checkOutput("rnd_chan", 64'(out_chan), 64'(m_chan));
                checkOutput("rnd_data", 64'(out_data), 64'(m_hold[m_chan]));
            end
            checkOutput("rnd_overrun", 64'(overrun), 64'(m_ovr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_out_scheduler.md
FB_OUT_SCHEDULER -- requirements
Module: fb_out_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 16, number of filter-bank bands.
REQ-002 SHALL have parameter DW, default 37, band sample width (sfix37_En32).
REQ-003 SHALL have parameter DECW, default 4, width of per-band decimation field.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port clk_enable  input  1  filter-bank sample strobe; the bands update on the same edge.
REQ-007 SHALL have port band_data  input  NCH*DW  flattened band outputs; band k at bits [k*DW +: DW].
REQ-008 SHALL have port dec_cfg  input  NCH*DECW  per-band decimation factor minus 1; band k at [k*DECW +: DECW].
REQ-009 SHALL have port cfg_load  input  1  latch dec_cfg and restart all band phases.
REQ-010 SHALL have port out_valid  output  1  serialized sample available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DW  serialized band sample.
REQ-013 SHALL have port out_chan  output  clog2(NCH)  band index of out_data.
REQ-014 SHALL have port overrun  output  1  sticky: a pending sample was overwritten.
REQ-015 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-016 SHALL hold per band: dec register, phase counter, DW-bit holding register, pending bit.
REQ-017 On clk_enable, a band with phase==0 SHALL be due: band_data captured into holding, pending set, phase reloaded with dec; other bands' phase decrements by 1.
REQ-018 A due band whose pending is already set and not transferred that cycle SHALL be overwritten with new data and SHALL set overrun.
REQ-019 A capture of band k in the same cycle as transfer of band k SHALL leave pending[k] set with new data, no overrun.
REQ-020 Output FSM SHALL have states IDLE and PRESENT; IDLE->PRESENT when any pending bit is set, grant chosen that cycle.
REQ-021 Grant SHALL be round-robin: first pending band searching upward (wrapping) from last granted + 1.
REQ-022 In PRESENT, out_valid=1, out_data=holding[grant], out_chan=grant; all SHALL hold stable until out_valid&&out_ready.
REQ-023 On transfer, pending[grant] SHALL clear (except per REQ-019); FSM goes to IDLE.
REQ-024 Captured sample SHALL reach out_valid no earlier than 1 cycle after the capturing edge; max throughput one sample per 2 cycles.
REQ-025 cfg_load SHALL copy dec_cfg into dec registers and set all phases to 0; pending, holding, FSM unaffected; cfg_load with clk_enable in same cycle: load wins, no capture that cycle.
REQ-026 Holding register of the granted band SHALL not change while PRESENT except per REQ-018 (overwrite updates out_data; out_chan unchanged).
REQ-027 overrun_clr coincident with a new overrun event SHALL leave overrun set.

Reset
REQ-028 reset_n low SHALL asynchronously force: out_valid=0, out_data=0, out_chan=0, overrun=0, FSM=IDLE, all pending=0, holding=0, phase=0, dec=0 (factor 1), last-grant=NCH-1 so band 0 wins first.
REQ-029 Reset mid-PRESENT SHALL drop out_valid immediately; the in-flight sample is discarded.

Configuration
REQ-030 Macro FB_SCHED_OVERRUN_EN defined SHALL build overrun detection per REQ-018/027.
REQ-031 Without FB_SCHED_OVERRUN_EN, overrun SHALL be constant 0 and overrun_clr ignored; overwrite behaviour unchanged.

Verification
REQ-032 Reset, dec all 0, one strobe with band k = k+1, out_ready=1 -> 16 transfers, out_chan 0..15 ascending, out_data k+1.
REQ-033 dec[3]=3, others 15, cfg_load, 8 strobes -> band 3 emitted on strobes 1 and 5, other bands on strobe 1 only.
REQ-034 out_ready=0 for 10 cycles in PRESENT -> out_valid, out_data, out_chan stable throughout; transfer on first ready cycle.
REQ-035 dec all 0, out_ready=0, two strobes -> overrun=1, second samples delivered; overrun_clr -> overrun=0; with macro undefined overrun stays 0.
REQ-036 reset_n low while PRESENT -> out_valid=0 same cycle, all pending 0; first grant after release is band 0.
